write_back_stage: RTL

- Parametrised successor of the pipeline write-back stage. Selects the result from one of three sources (ALU, memory, link address) and registers it with valid/stall/flush control.
- Drives the register-file write port (enable, address, data) one cycle after acceptance.
- Keeps a wrap-around retired-instruction counter.
- Sits between the MEM/WB pipeline register and the register file.

---
 rtl/write_back_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/write_back_stage.sv
// write_back_stage: pipeline write-back stage between the MEM/WB register
// and the register file. Selects ALU, memory or link-address result,
// registers it under rst/flush/stall control, drives the register-file
// write port one cycle after acceptance and counts retired instructions.
//
// Optional feature macro: WB_SUBWORD_LOAD_EN
//   defined   -> byte/half loads are extracted from the low 32 bits of
//                mem_data and sign/zero extended (needs DATA_W >= 32)
//   undefined -> mem_data passes through unmodified; load_size,
//                load_unsigned and byte_off are ignored
//
// Handshake: in_valid qualifies the input bundle; there is no ready. The
// stage accepts whenever in_valid=1 and neither rst, flush nor stall is
// asserted. stall freezes every register (a held write is re-presented to
// the register file, which is idempotent). flush turns the next output into
// a bubble and wins over stall. out_valid/rf_* are valid one cycle after
// acceptance.
module write_back_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [DATA_W-1:0]     link_addr,
  input  logic [1:0]            res_sel,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [1:0]            byte_off,
  output logic                  out_valid,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [CNT_W-1:0]      retired_cnt
);

  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  logic [DATA_W-1:0] mem_value;
  logic [DATA_W-1:0] sel_result;
  logic              accept;

`ifdef WB_SUBWORD_LOAD_EN
  logic [31:0] mem_lo;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign mem_lo    = mem_data[31:0];
  assign load_byte = mem_lo[{byte_off, 3'b000} +: 8];
  // Half loads are aligned upstream, so byte_off[0] plays no part here.
  assign load_half = mem_lo[{byte_off[1], 4'b0000} +: 16];

  // Extract and extend the loaded sub-word; word and reserved sizes pass through.
  always_comb begin
    mem_value = mem_data;
    case (load_size)
      2'b10:   mem_value = {{(DATA_W-8){~load_unsigned & load_byte[7]}}, load_byte};
      2'b01:   mem_value = {{(DATA_W-16){~load_unsigned & load_half[15]}}, load_half};
      default: mem_value = mem_data;
    endcase
  end
`else
  logic unused_subword;

  assign unused_subword = ^{load_size, load_unsigned, byte_off};
  assign mem_value      = mem_data;
`endif

  // Result mux; the reserved encoding 11 falls back to the ALU result.
  always_comb begin
    sel_result = alu_result;
    case (res_sel)
      SEL_MEM:  sel_result = mem_value;
      SEL_LINK: sel_result = link_addr;
      default:  sel_result = alu_result;
    endcase
  end

  assign accept = in_valid & ~stall & ~flush;

  // Output registers and retired counter with rst > flush > stall > accept priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      retired_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      rf_we     <= 1'b0;
    end else if (stall) begin
      out_valid <= out_valid;
      rf_we     <= rf_we;
    end else if (accept) begin
      out_valid   <= 1'b1;
      rf_we       <= reg_write & (rd_addr != '0);
      rf_waddr    <= rd_addr;
      rf_wdata    <= sel_result;
      retired_cnt <= retired_cnt + CNT_W'(1);
    end else begin
      out_valid <= 1'b0;
      rf_we     <= 1'b0;
    end
  end

endmodule
